// File: rtl/mtl_power_sequencer.sv
// Power-up/power-down sequencer for the MTL LCD panel: supply, then timing generator,
// then a ramped backlight PWM; shutdown unwinds the same steps in reverse.
module mtl_power_sequencer #(
  parameter int PWR_DLY  = 33000,
  parameter int FRAMES   = 10,
  parameter int PWM_BITS = 8,
  parameter int BL_DUTY  = 200,
  parameter int RAMP_DIV = 33000
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iVS,
  input  logic                iSHDN,
  output logic                oDISP_EN,
  output logic                oTIMING_EN,
  output logic                oBL_PWM,
  output logic                oREADY,
  output logic [PWM_BITS-1:0] oDUTY
);

  localparam int DLY_MAX = (PWR_DLY > RAMP_DIV) ? PWR_DLY : RAMP_DIV;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam int FRM_W   = $clog2(FRAMES + 1);

  localparam logic [DLY_W-1:0]    PWR_TC     = DLY_W'(PWR_DLY - 1);
  localparam logic [DLY_W-1:0]    RAMP_TC    = DLY_W'(RAMP_DIV - 1);
  localparam logic [DLY_W-1:0]    DLY_ONE    = DLY_W'(1);
  localparam logic [FRM_W-1:0]    FRM_TC     = FRM_W'(FRAMES - 1);
  localparam logic [FRM_W-1:0]    FRM_ONE    = FRM_W'(1);
  localparam logic [PWM_BITS-1:0] DUTY_FINAL = PWM_BITS'(BL_DUTY);
  localparam logic [PWM_BITS-1:0] DUTY_ONE   = PWM_BITS'(1);

  typedef enum logic [2:0] {
    S_OFF,
    S_PWR_UP,
    S_FRM_UP,
    S_RAMP_UP,
    S_ON,
    S_RAMP_DN,
    S_FRM_DN,
    S_PWR_DN
  } state_t;

  state_t              r_state;
  logic [DLY_W-1:0]    r_dly;
  logic [FRM_W-1:0]    r_frm;
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] r_pc;
  logic                r_vs_prev;
  logic                r_disp_en;
  logic                r_timing_en;
  logic                r_bl_pwm;
  logic                r_ready;

  logic                w_vs_fall;
  logic [PWM_BITS-1:0] w_duty_inc;
  logic [PWM_BITS-1:0] w_duty_dec;

  // Counters hold at their terminal value instead of wrapping.
  function automatic logic [DLY_W-1:0] sat_inc_dly(input logic [DLY_W-1:0] c,
                                                   input logic [DLY_W-1:0] tc);
    return (c >= tc) ? c : c + DLY_ONE;
  endfunction

  function automatic logic [FRM_W-1:0] sat_inc_frm(input logic [FRM_W-1:0] c);
    return (c >= FRM_TC) ? c : c + FRM_ONE;
  endfunction

  assign w_vs_fall  = r_vs_prev & ~iVS;
  assign w_duty_inc = r_duty + DUTY_ONE;
  assign w_duty_dec = r_duty - DUTY_ONE;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state     <= S_OFF;
      r_dly       <= '0;
      r_frm       <= '0;
      r_duty      <= '0;
      r_pc        <= '0;
      r_vs_prev   <= 1'b1;
      r_disp_en   <= 1'b0;
      r_timing_en <= 1'b0;
      r_bl_pwm    <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_vs_prev   <= iVS;
      r_pc        <= r_pc + DUTY_ONE;
      r_bl_pwm    <= (r_pc < r_duty);
      // Enables decode the current state, so they follow a state change by one cycle.
      r_disp_en   <= (r_state != S_OFF);
      r_timing_en <= (r_state inside {S_FRM_UP, S_RAMP_UP, S_ON, S_RAMP_DN, S_FRM_DN});
      r_ready     <= (r_state == S_ON);

      case (r_state)
        S_OFF: begin
          if (!iSHDN) begin
            r_state <= S_PWR_UP;
            r_dly   <= '0;
          end
        end
        S_PWR_UP: begin
          if (iSHDN) begin
            r_state <= S_PWR_DN;
            r_dly   <= '0;
          end else if (r_dly == PWR_TC) begin
            r_state <= S_FRM_UP;
            r_frm   <= '0;
          end else begin
            r_dly <= sat_inc_dly(r_dly, PWR_TC);
          end
        end
        S_FRM_UP: begin
          if (iSHDN) begin
            r_state <= S_FRM_DN;
            r_frm   <= '0;
          end else if (w_vs_fall) begin
            if (r_frm == FRM_TC) begin
              r_state <= S_RAMP_UP;
              r_dly   <= '0;
            end else begin
              r_frm <= sat_inc_frm(r_frm);
            end
          end
        end
        S_RAMP_UP: begin
          if (iSHDN) begin
            r_state <= S_RAMP_DN;
            r_dly   <= '0;
          end else if (r_dly == RAMP_TC) begin
            r_dly  <= '0;
            r_duty <= w_duty_inc;
            if (w_duty_inc == DUTY_FINAL) r_state <= S_ON;
          end else begin
            r_dly <= sat_inc_dly(r_dly, RAMP_TC);
          end
        end
        S_ON: begin
          r_duty <= DUTY_FINAL;
          if (iSHDN) begin
            r_state <= S_RAMP_DN;
            r_dly   <= '0;
          end
        end
        // Down states ignore iSHDN so that every power-down step completes.
        S_RAMP_DN: begin
          if (r_duty == '0) begin
            r_state <= S_FRM_DN;
            r_frm   <= '0;
          end else if (r_dly == RAMP_TC) begin
            r_dly  <= '0;
            r_duty <= w_duty_dec;
          end else begin
            r_dly <= sat_inc_dly(r_dly, RAMP_TC);
          end
        end
        S_FRM_DN: begin
          if (w_vs_fall) begin
            if (r_frm == FRM_TC) begin
              r_state <= S_PWR_DN;
              r_dly   <= '0;
            end else begin
              r_frm <= sat_inc_frm(r_frm);
            end
          end
        end
        S_PWR_DN: begin
          if (r_dly == PWR_TC) begin
            r_state <= S_OFF;
          end else begin
            r_dly <= sat_inc_dly(r_dly, PWR_TC);
          end
        end
        default: r_state <= S_OFF;
      endcase
    end
  end

  assign oDISP_EN   = r_disp_en;
  assign oTIMING_EN = r_timing_en;
  assign oBL_PWM    = r_bl_pwm;
  assign oREADY     = r_ready;
  assign oDUTY      = r_duty;

endmodule
